// File: rtl/pe1_pkg.sv
// rtl/pe1_pkg.sv - shared PE1 multiplier widths and the carry-save vector type
package pe1_pkg;

    localparam int CSA_W     = 15;
    localparam int CPA_SPLIT = 8;

    typedef logic [CSA_W-1:0] csa_vec_t;

endpackage

// File: rtl/cpa2_if.sv
// rtl/cpa2_if.sv - carry-save pair in / resolved sum out, both valid/ready handshaked
interface cpa2_if
    import pe1_pkg::*;
#(
    parameter int W = CSA_W
);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] s;
    logic [W-1:0] c;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;

    modport master (
        output in_valid, s, c, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, s, c, out_ready,
        output in_ready, out_valid, result
    );

endinterface

// File: rtl/fa.sv
// rtl/fa.sv - one-bit full adder cell
module fa (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/rca.sv
// rtl/rca.sv - N-bit ripple-carry adder chained from fa cells
module rca #(
    parameter int N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    // Each bit keeps its own carry net so the chain is not one self-referencing vector.
    for (genvar i = 0; i < N; i++) begin : g_bit
        logic ci;
        logic co;
        if (i == 0) begin : g_first
            assign ci = cin_i;
        end else begin : g_next
            assign ci = g_bit[i-1].co;
        end
        fa u_fa (
            .a_i   (a_i[i]),
            .b_i   (b_i[i]),
            .cin_i (ci),
            .sum_o (sum_o[i]),
            .cout_o(co)
        );
    end

    assign cout_o = g_bit[N-1].co;

endmodule

// File: rtl/cpa2.sv
// rtl/cpa2.sv - two-stage pipelined carry-propagate resolver for a carry-save pair
module cpa2
    import pe1_pkg::*;
#(
    parameter int W     = CSA_W,
    parameter int SPLIT = CPA_SPLIT
) (
    input  logic   clk,
    input  logic   reset,
    cpa2_if.slave  bus
);

    localparam int HW = W - SPLIT;

    logic            v1_q;
    logic            v2_q;
    logic            adv1;
    logic            adv2;
    logic [SPLIT-1:0] lo_d;
    logic [SPLIT-1:0] lo_q;
    logic            cy1_d;
    logic            cy1_q;
    logic [HW-1:0]   shi_q;
    logic [HW-1:0]   chi_q;
    logic [HW-1:0]   hi_d;
    logic [W-1:0]    res_q;
    logic            unused_cy2;

    assign adv2 = !v2_q || bus.out_ready;
    assign adv1 = !v1_q || adv2;

    rca #(.N(SPLIT)) u_rca_lo (
        .a_i   (bus.s[SPLIT-1:0]),
        .b_i   (bus.c[SPLIT-1:0]),
        .cin_i (1'b0),
        .sum_o (lo_d),
        .cout_o(cy1_d)
    );

    // Carry out of the top column is dropped, as in the compressor tree.
    rca #(.N(HW)) u_rca_hi (
        .a_i   (shi_q),
        .b_i   (chi_q),
        .cin_i (cy1_q),
        .sum_o (hi_d),
        .cout_o(unused_cy2)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            lo_q  <= '0;
            cy1_q <= 1'b0;
            shi_q <= '0;
            chi_q <= '0;
            res_q <= '0;
        end else begin
            if (adv1) begin
                v1_q <= bus.in_valid;
            end
            // Data registers only move when a valid item lands in them.
            if (adv1 && bus.in_valid) begin
                lo_q  <= lo_d;
                cy1_q <= cy1_d;
                shi_q <= bus.s[W-1:SPLIT];
                chi_q <= bus.c[W-1:SPLIT];
            end
            if (adv2) begin
                v2_q <= v1_q;
            end
            if (adv2 && v1_q) begin
                res_q <= {hi_d, lo_q};
            end
        end
    end

    assign bus.in_ready  = adv1;
    assign bus.out_valid = v2_q;
    assign bus.result    = res_q;

endmodule

// File: tb/tb_cpa2.sv
// tb/tb_cpa2.sv - self-checking bench for cpa2 against an arithmetic scoreboard
module tb_cpa2;
    import pe1_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpa2_if #(.W(CSA_W)) bus ();

    cpa2 #(.W(CSA_W), .SPLIT(CPA_SPLIT)) dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned expq[$];
    logic        acc;
    logic        emt;
    logic        hold_pending = 1'b0;
    logic [31:0] hold_result;
    logic        use_exp = 1'b0;
    int unsigned exp_val;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned model_sum(input int unsigned a, input int unsigned b);
        return (a + b) % (32'd1 << CSA_W);
    endfunction

    // One clock cycle: called just after a falling edge with inputs already driven.
    task automatic cycle();
        #1;
        if (hold_pending) begin
            check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
            check("hold_result", {17'd0, bus.result}, hold_result);
        end
        acc = bus.in_valid && bus.in_ready;
        emt = bus.out_valid && bus.out_ready;
        if (emt) begin
            if (expq.size() == 0) check("spurious_out", 32'd1, 32'd0);
            else check("result", {17'd0, bus.result}, expq.pop_front());
        end
        if (acc) expq.push_back(use_exp ? exp_val : model_sum(bus.s, bus.c));
        hold_pending = bus.out_valid && !bus.out_ready;
        hold_result  = {17'd0, bus.result};
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic randomize_pair();
        bus.s = csa_vec_t'($urandom);
        bus.c = csa_vec_t'($urandom);
    endtask

    task automatic send_exp(input int unsigned sv, input int unsigned cv, input int unsigned ev);
        bus.s       = csa_vec_t'(sv);
        bus.c       = csa_vec_t'(cv);
        bus.in_valid = 1'b1;
        use_exp     = 1'b1;
        exp_val     = ev;
        cycle();
        use_exp      = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while ((expq.size() != 0 || bus.out_valid) && guard < 20) begin
            cycle();
            guard++;
        end
        check("drain_empty", expq.size(), 32'd0);
    endtask

    initial begin
        int sent;
        int guard;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.s         = '0;
        bus.c         = '0;
        #1;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_result", {17'd0, bus.result}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single pair with latency check
        send_exp(32'h1234, 32'h0101, 32'h1335);
        check("single_acc", {31'd0, acc}, 32'd1);
        check("lat_cycle1", {31'd0, bus.out_valid}, 32'd0);
        cycle();
        check("lat_cycle2", {31'd0, bus.out_valid}, 32'd1);
        cycle();
        drain();

        send_exp(32'h00FF, 32'h0001, 32'h0100);
        drain();
        send_exp(32'h7FFF, 32'h0001, 32'h0000);
        drain();
        send_exp(32'h7FFF, 32'h7FFF, 32'h7FFE);
        drain();

        // Backpressure: two pairs absorbed, third held
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        randomize_pair();
        #1 check("bp_ready_a", {31'd0, bus.in_ready}, 32'd1);
        cycle();
        randomize_pair();
        #1 check("bp_ready_b", {31'd0, bus.in_ready}, 32'd1);
        cycle();
        randomize_pair();
        #1 check("bp_ready_c0", {31'd0, bus.in_ready}, 32'd0);
        cycle();
        #1 check("bp_ready_c1", {31'd0, bus.in_ready}, 32'd0);
        cycle();
        bus.out_ready = 1'b1;
        #1 check("bp_full_shift", {31'd0, bus.in_ready}, 32'd1);
        cycle();
        check("bp_c_acc", {31'd0, acc}, 32'd1);
        drain();

        // Random streaming with random backpressure
        sent  = 0;
        guard = 0;
        bus.in_valid = 1'b1;
        randomize_pair();
        while (sent < 1000 && guard < 20000) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            cycle();
            guard++;
            if (acc) begin
                sent++;
                randomize_pair();
            end
        end
        check("stream_count", sent, 32'd1000);
        drain();

        // Full throughput: no bubbles
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            randomize_pair();
            #1 check("tp_in_ready", {31'd0, bus.in_ready}, 32'd1);
            if (i >= 2) check("tp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            cycle();
        end
        drain();

        // Reset with both stages holding data
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        randomize_pair();
        cycle();
        randomize_pair();
        cycle();
        check("pre_rst_full", {31'd0, bus.out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst_result", {17'd0, bus.result}, 32'd0);
        check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        expq.delete();
        hold_pending = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("post_rst_idle", {31'd0, bus.out_valid}, 32'd0);
            cycle();
        end
        send_exp(32'h0ABC, 32'h0111, 32'h0BCD);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
